// File: rtl/mul_gate_pkg.sv
// mul_gate_pkg: opcode encoding and widths shared by the mul_gate slice.
package mul_gate_pkg;

    localparam int MUL_GATE_SEL_W = 2;

    typedef enum logic [MUL_GATE_SEL_W-1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } mul_gate_op_e;

endpackage : mul_gate_pkg

// File: rtl/mul_gate_core.sv
// mul_gate_core: purely combinational selectable bitwise gate.
// Optional feature macro MUL_GATE_INVERT_EN adds an 'inv' input that
// complements the selected function.
module mul_gate_core
    import mul_gate_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [MUL_GATE_SEL_W-1:0] sel,
    input  logic [WIDTH-1:0]          a,
    input  logic [WIDTH-1:0]          b,
`ifdef MUL_GATE_INVERT_EN
    input  logic                      inv,
`endif
    output logic [WIDTH-1:0]          result
);

    logic [WIDTH-1:0] func_s;

    // Select the bitwise function; unknown or illegal opcodes fall back to AND.
    always_comb begin
        func_s = a & b;
        case (mul_gate_op_e'(sel))
            OP_AND:  func_s = a & b;
            OP_OR:   func_s = a | b;
            OP_XOR:  func_s = a ^ b;
            OP_NAND: func_s = ~(a & b);
            default: func_s = a & b;
        endcase
    end

`ifdef MUL_GATE_INVERT_EN
    // Optionally complement the selected function.
    always_comb begin
        result = func_s;
        if (inv) begin
            result = ~func_s;
        end else begin
            result = func_s;
        end
    end
`else
    // Without the invert option the selected function is the result.
    always_comb begin
        result = func_s;
    end
`endif

endmodule : mul_gate_core

// File: rtl/mul_gate.sv
// mul_gate: selectable two-input bitwise gate with registered result.
// Optional feature macro MUL_GATE_INVERT_EN adds the 'inv' input port.
module mul_gate
    import mul_gate_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [MUL_GATE_SEL_W-1:0] sel,
    input  logic [WIDTH-1:0]          a,
    input  logic [WIDTH-1:0]          b,
    input  logic                      in_valid,
`ifdef MUL_GATE_INVERT_EN
    input  logic                      inv,
`endif
    output logic [WIDTH-1:0]          z,
    output logic                      out_valid
);

    logic [WIDTH-1:0] result_s;
    logic [WIDTH-1:0] z_r;
    logic             out_valid_r;

    mul_gate_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .sel    (sel),
        .a      (a),
        .b      (b),
`ifdef MUL_GATE_INVERT_EN
        .inv    (inv),
`endif
        .result (result_s)
    );

    // Capture the result on qualified cycles; hold it otherwise, valid tracks in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_r         <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
        end else if (in_valid) begin
            z_r         <= result_s;
            out_valid_r <= 1'b1;
        end else begin
            z_r         <= z_r;
            out_valid_r <= 1'b0;
        end
    end

    assign z         = z_r;
    assign out_valid = out_valid_r;

endmodule : mul_gate

// File: tb/tb_mul_gate.sv
// tb_mul_gate: directed-vector bench for mul_gate (WIDTH=1 and WIDTH=4 instances).
module tb_mul_gate;

    logic       clk;
    logic       rst_n;
    logic [1:0] sel;
    logic       in_valid;
    logic       a1;
    logic       b1;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       inv;
    logic       z1;
    logic       ov1;
    logic [3:0] z4;
    logic       ov4;

    int n_cmp;
    int n_err;

    mul_gate #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .a         (a1),
        .b         (b1),
        .in_valid  (in_valid),
`ifdef MUL_GATE_INVERT_EN
        .inv       (inv),
`endif
        .z         (z1),
        .out_valid (ov1)
    );

    mul_gate #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .a         (a4),
        .b         (b4),
        .in_valid  (in_valid),
`ifdef MUL_GATE_INVERT_EN
        .inv       (inv),
`endif
        .z         (z4),
        .out_valid (ov4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        sel      = 2'b00;
        in_valid = 1'b0;
        a1       = 1'b0;
        b1       = 1'b0;
        a4       = 4'b0000;
        b4       = 4'b0000;
        inv      = 1'b0;

        #2;
        check("rst_z1", {7'd0, z1}, 8'h00);
        check("rst_ov1", {7'd0, ov1}, 8'h00);
        check("rst_z4", {4'd0, z4}, 8'h00);
        step();
        rst_n = 1'b1;
        step();

        // Opcode sweep, WIDTH=1.
        in_valid = 1'b1;
        sel = 2'b00; a1 = 1'b0; b1 = 1'b1; step();
        check("and_z", {7'd0, z1}, 8'h00);
        check("and_ov", {7'd0, ov1}, 8'h01);
        sel = 2'b01; a1 = 1'b1; b1 = 1'b0; step();
        check("or_z", {7'd0, z1}, 8'h01);
        sel = 2'b10; a1 = 1'b0; b1 = 1'b0; step();
        check("xor_z", {7'd0, z1}, 8'h00);
        sel = 2'b11; a1 = 1'b1; b1 = 1'b0; step();
        check("nand_z", {7'd0, z1}, 8'h01);

        // Hold: z stays 1 when in_valid drops.
        in_valid = 1'b0; sel = 2'b00; a1 = 1'b0; b1 = 1'b0; step();
        check("hold_z", {7'd0, z1}, 8'h01);
        check("hold_ov", {7'd0, ov1}, 8'h00);
        step();
        check("hold2_z", {7'd0, z1}, 8'h01);

        // Wide sweep on consecutive cycles.
        in_valid = 1'b1; a4 = 4'b1100; b4 = 4'b1010;
        sel = 2'b00; step();
        check("w_and", {4'd0, z4}, 8'h08);
        check("w_and_ov", {7'd0, ov4}, 8'h01);
        sel = 2'b01; step();
        check("w_or", {4'd0, z4}, 8'h0e);
        sel = 2'b10; step();
        check("w_xor", {4'd0, z4}, 8'h06);
        sel = 2'b11; step();
        check("w_nand", {4'd0, z4}, 8'h07);
        check("w_nand_ov", {7'd0, ov4}, 8'h01);

`ifdef MUL_GATE_INVERT_EN
        inv = 1'b1;
        sel = 2'b10; a1 = 1'b1; b1 = 1'b0; step();
        check("inv_xor", {7'd0, z1}, 8'h00);
        sel = 2'b11; a1 = 1'b1; b1 = 1'b1; step();
        check("inv_nand", {7'd0, z1}, 8'h01);
        sel = 2'b00; a4 = 4'b1100; b4 = 4'b1010; step();
        check("inv_w_and", {4'd0, z4}, 8'h07);
        inv = 1'b0;
`endif

        // Asynchronous reset mid-cycle with z1 = 1 loaded.
        sel = 2'b01; a1 = 1'b1; b1 = 1'b0; step();
        check("pre_rst_z", {7'd0, z1}, 8'h01);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_z", {7'd0, z1}, 8'h00);
        check("async_ov", {7'd0, ov1}, 8'h00);
        rst_n = 1'b1;

        // Reset during an in_valid stream.
        in_valid = 1'b1; sel = 2'b00; a4 = 4'b1100; b4 = 4'b1010;
        step();
        check("stream_z", {4'd0, z4}, 8'h08);
        rst_n = 1'b0;
        step();
        check("strm_rst1_z", {4'd0, z4}, 8'h00);
        check("strm_rst1_ov", {7'd0, ov4}, 8'h00);
        step();
        check("strm_rst2_z", {4'd0, z4}, 8'h00);
        check("strm_rst2_ov", {7'd0, ov4}, 8'h00);
        rst_n = 1'b1; sel = 2'b10;
        step();
        check("post_rel_z", {4'd0, z4}, 8'h06);
        check("post_rel_ov", {7'd0, ov4}, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mul_gate
